// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs instruction requests into MIPS words and writes them to instruction memory
module instr_encoder_loader #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2,
      S_FULL = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                err_q, err_d;
   logic                imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [31:0]         imem_wdata_q, imem_wdata_d;
   logic [31:0]         word_c;
   logic                accept_c;

   // Encode the request fields into a 32-bit word using the decoder's opcode set
   always_comb begin
      word_c = 32'd0;
      case (op)
         3'd0:    word_c = {6'b000000, rs, rt, rd, shamt, funct};
         3'd1:    word_c = {6'b100011, rs, rt, imm};
         3'd2:    word_c = {6'b000100, rs, rt, imm};
         3'd3:    word_c = {6'b000010, target};
         3'd4:    word_c = {6'b001101, rs, rt, imm};
         3'd5:    word_c = {6'b001000, rs, rt, imm};
         3'd6:    word_c = {6'b101011, rs, rt, imm};
         default: word_c = 32'd0;
      endcase
   end

   // Session FSM: next state, write pulse, pointer/count and sticky error
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      err_d        = err_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      accept_c     = in_valid && (state_q == S_LOAD);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept_c) begin
               if (op == 3'd7) begin
                  err_d = 1'b1;
               end else begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = count_q[ADDR_W-1:0];
                  imem_wdata_d = word_c;
                  count_d      = count_q + 1'b1;
               end
            end
            // Filling the memory wins over a coincident finish
            if (count_d == DEPTH_C) begin
               state_d = S_FULL;
            end else if (finish) begin
               state_d = S_DONE;
            end
         end
         S_DONE, S_FULL: begin
            if (start) begin
               state_d = S_LOAD;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         err_q        <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         err_q        <= err_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
      end
   end

   assign in_ready   = (state_q == S_LOAD);
   assign busy       = (state_q == S_LOAD);
   assign done       = (state_q == S_DONE) || (state_q == S_FULL);
   assign full       = (state_q == S_FULL);
   assign err        = err_q;
   assign count      = count_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - vector table, directed corner cases and random run against a reference model
module tb_instr_encoder_loader;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              finish = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        op = 3'd0;
   logic [4:0]        rs = 5'd0, rt = 5'd0, rd = 5'd0, shamt = 5'd0;
   logic [5:0]        funct = 6'd0;
   logic [15:0]       imm = 16'd0;
   logic [25:0]       target = 26'd0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              busy, done, full, err;

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm(imm), .target(target), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .count(count), .busy(busy), .done(done),
      .full(full), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;
   int writes = 0;

   // reference model: session phase 0 idle, 1 loading, 2 finished, 3 memory full
   int          m_phase = 0;
   int          m_cnt = 0;
   bit          m_err = 0;
   bit          m_we = 0;
   int          m_addr = 0;
   logic [31:0] m_word = 0;

   typedef struct {
      int          op, rs, rt, rd, sh, fn, imm, tgt;
      logic [31:0] exp;
   } vec_t;

   function automatic logic [31:0] ref_word(int o, int a, int b, int c, int sh, int fn, int im, int tg);
      int opcodes [7] = '{0, 35, 4, 2, 13, 8, 43};
      logic [31:0] w;
      if (o == 3)
         w = (32'(opcodes[o]) << 26) + 32'(tg);
      else if (o == 0)
         w = (32'(a) << 21) + (32'(b) << 16) + (32'(c) << 11) + (32'(sh) << 6) + 32'(fn);
      else
         w = (32'(opcodes[o]) << 26) + (32'(a) << 21) + (32'(b) << 16) + 32'(im);
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // advance the model by one clock using the inputs currently driven
   task automatic model_step();
      m_we = 0;
      if (m_phase == 1) begin
         if (in_valid) begin
            if (op == 3'd7) m_err = 1;
            else begin
               m_we = 1;
               m_addr = m_cnt;
               m_word = ref_word(int'(op), int'(rs), int'(rt), int'(rd), int'(shamt),
                                 int'(funct), int'(imm), int'(target));
               m_cnt++;
            end
         end
         if (m_cnt == DEPTH) m_phase = 3;
         else if (finish) m_phase = 2;
      end else if (start) begin
         m_phase = 1;
         m_cnt = 0;
         m_err = 0;
      end
   endtask

   task automatic check_all();
      chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_phase >= 2));
      chk("full", 32'(full), 32'(m_phase == 3));
      chk("err", 32'(err), 32'(m_err));
      chk("count", 32'(count), 32'(m_cnt));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      if (m_we) begin
         chk("imem_addr", 32'(imem_addr), 32'(m_addr));
         chk("imem_wdata", imem_wdata, m_word);
      end
      if (imem_we) writes++;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input vec_t v);
      op = 3'(v.op); rs = 5'(v.rs); rt = 5'(v.rt); rd = 5'(v.rd);
      shamt = 5'(v.sh); funct = 6'(v.fn); imm = 16'(v.imm); target = 26'(v.tgt);
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_err = 0; m_we = 0; m_addr = 0; m_word = 0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_we"}, 32'(imem_we), 0);
      chk({tag, "_addr"}, 32'(imem_addr), 0);
      chk({tag, "_wdata"}, imem_wdata, 0);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_flags"}, {26'd0, in_ready, busy, done, full, err, 1'b0}, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1; cycle(); start = 1'b0;
   endtask

   task automatic pulse_finish();
      finish = 1'b1; cycle(); finish = 1'b0;
   endtask

   vec_t vecs [7];
   vec_t v;

   initial begin
      // unused fields carry junk to show they are ignored
      vecs[0] = '{0, 1, 2, 3, 0, 'h20, 'hBEEF, 'h3FFFFFF, 32'h00221820};
      vecs[1] = '{1, 0, 8, 31, 17, 'h3F, 4, 'h1234567, 32'h8C080004};
      vecs[2] = '{2, 8, 9, 7, 5, 'h11, 'hFFFF, 'h2AAAAAA, 32'h1109FFFF};
      vecs[3] = '{3, 31, 31, 31, 31, 'h3F, 'hFFFF, 'h0000010, 32'h08000010};
      vecs[4] = '{4, 0, 5, 9, 3, 'h01, 'h00FF, 'h1555555, 32'h340500FF};
      vecs[5] = '{5, 0, 5, 9, 3, 'h01, 'h00FF, 'h1555555, 32'h200500FF};
      vecs[6] = '{6, 29, 5, 2, 1, 'h2A, 8, 'h0F0F0F0, 32'hAFA50008};

      // reset state
      #1;
      check_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;

      // table vectors back to back, then finish
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         drive(v);
         in_valid = 1'b1;
         cycle();
         chk("vec_word", imem_wdata, v.exp);
         chk("vec_addr", 32'(imem_addr), 32'(i));
      end
      in_valid = 1'b0;
      pulse_finish();
      chk("vec_done", 32'(done), 1);
      chk("vec_count", 32'(count), 7);
      in_valid = 1'b1;
      cycle();
      cycle();
      in_valid = 1'b0;

      // illegal op between two legal words
      pulse_start();
      in_valid = 1'b1;
      drive(vecs[1]); cycle();
      op = 3'd7; cycle();
      chk("illegal_no_we", 32'(imem_we), 0);
      drive(vecs[2]); cycle();
      chk("illegal_next_addr", 32'(imem_addr), 1);
      in_valid = 1'b0;
      pulse_finish();
      chk("illegal_err", 32'(err), 1);
      chk("illegal_count", 32'(count), 2);
      pulse_start();
      chk("illegal_err_clear", 32'(err), 0);

      // fill to DEPTH with finish on the last accept
      writes = 0;
      in_valid = 1'b1;
      for (int i = 0; i < DEPTH + 5; i++) begin
         op = 3'($urandom_range(0, 6));
         rs = 5'($urandom); rt = 5'($urandom); imm = 16'($urandom); target = 26'($urandom);
         finish = (i == DEPTH - 1);
         cycle();
      end
      finish = 1'b0;
      in_valid = 1'b0;
      chk("full_writes", 32'(writes), DEPTH);
      chk("full_flag", {29'd0, full, done, in_ready}, 32'b110);
      chk("full_count", 32'(count), DEPTH);

      // reset one cycle after an accept
      pulse_start();
      in_valid = 1'b1;
      drive(vecs[0]);
      cycle();
      in_valid = 1'b0;
      drive(vecs[4]);
      reset = 1'b1;
      #1;
      model_reset();
      check_zero("midreset");
      @(posedge clk); #1;
      check_zero("midreset_hold");
      reset = 1'b0;
      pulse_start();
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("post_reset_addr", 32'(imem_addr), 0);
      chk("post_reset_word", imem_wdata, 32'h340500FF);

      // randomized sessions
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 39) == 0);
         finish = ($urandom_range(0, 29) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         op = 3'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
         shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
         cycle();
      end
      start = 1'b0; finish = 1'b0; in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
